// File: rtl/keypad_pkg.sv
// Shared types and key map for the keypad scanner.
// Holds FSM states, frame results and the row/col-to-code lookup.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    REL_DB
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_e;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_lookup(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = KEY_0;
    case ({r, c})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_A;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h7: k = KEY_B;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = KEY_0;
      4'hE: k = KEY_HASH;
      4'hF: k = KEY_D;
      default: k = KEY_0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to all-ones so idle active-low lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two-stage metastability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, frame evaluation, debounce.
// Emits a one-cycle key_valid with key_code and a key_held level.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 8,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DB        = 4'(DEBOUNCE_FRAMES);
  localparam logic [1:0] COL_LAST  = 2'd3;

  logic [3:0] row_s;

  sync_2ff #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (row),
    .q_o   (row_s)
  );

  logic [7:0] slot_q, slot_d;
  logic [1:0] cidx_q, cidx_d;
  logic [3:0] col_q, col_d;
  logic [1:0] acc_n_q, acc_n_d;
  logic [3:0] acc_code_q, acc_code_d;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  logic       sample, frame_end;
  logic [3:0] low;
  logic       multi_row, one_row;
  logic [1:0] rsel;
  logic [1:0] hit_n;
  logic [3:0] hit_code;
  frame_e     fres;
  logic [3:0] cnt_inc;

  assign sample    = scan_en && (slot_q == SLOT_LAST);
  assign frame_end = sample && (cidx_q == COL_LAST);
  assign low       = ~row_s;
  assign multi_row = |(low & (low - 4'd1));
  assign one_row   = |low && !multi_row;
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  // Fold this slot's rows into the running frame summary
  always_comb begin
    rsel     = 2'd0;
    case (low)
      4'b0010: rsel = 2'd1;
      4'b0100: rsel = 2'd2;
      4'b1000: rsel = 2'd3;
      default: rsel = 2'd0;
    endcase
    hit_n    = acc_n_q;
    hit_code = acc_code_q;
    if (multi_row || (one_row && acc_n_q != 2'd0)) begin
      hit_n = 2'd2;
    end else if (one_row) begin
      hit_n    = 2'd1;
      hit_code = key_lookup(rsel, cidx_q);
    end
    fres = FR_MULTI;
    if (hit_n == 2'd0)      fres = FR_NONE;
    else if (hit_n == 2'd1) fres = FR_SINGLE;
  end

  // Slot/column timing and frame accumulator next state
  always_comb begin
    slot_d     = slot_q;
    cidx_d     = cidx_q;
    col_d      = col_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (!scan_en) begin
      slot_d     = 8'd0;
      cidx_d     = 2'd0;
      col_d      = 4'hF;
      acc_n_d    = 2'd0;
      acc_code_d = 4'd0;
    end else if (sample) begin
      slot_d = 8'd0;
      cidx_d = cidx_q + 2'd1;
      col_d  = ~(4'b0001 << cidx_d);
      if (frame_end) begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_n_d    = hit_n;
        acc_code_d = hit_code;
      end
    end else begin
      slot_d = slot_q + 8'd1;
      col_d  = ~(4'b0001 << cidx_q);
    end
  end

  // Scan timing registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q     <= 8'd0;
      cidx_q     <= 2'd0;
      col_q      <= 4'b1110;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      slot_q     <= slot_d;
      cidx_q     <= cidx_d;
      col_q      <= col_d;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Debounce FSM, stepped once per frame end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (!scan_en) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      held_d  = 1'b0;
    end else if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (fres == FR_SINGLE) begin
            cand_d = hit_code;
            if (DB == 4'd1) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
              code_d  = hit_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (fres == FR_SINGLE && hit_code == cand_q) begin
            if (cnt_inc >= DB) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (fres == FR_SINGLE) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (fres == FR_NONE) begin
            if (DB == 4'd1) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              held_d  = 1'b0;
            end else begin
              state_d = REL_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (fres == FR_NONE) begin
            if (cnt_inc >= DB) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              held_d  = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
  end

  // Debounce FSM and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
